ps2_rx: RTL
===========

# ps2_rx

PS/2 device-to-host byte receiver, the stage directly upstream of the keyboard make/break sequencer. Synchronizes and de-glitches the raw PS2_CLOCK/PS2_DATA pins, deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop) and emits each good byte with a one-cycle `is_pressed` strobe. Bad frames are dropped and flagged; stalled frames are aborted by a timeout so the receiver always resynchronizes.

## Interface
- FILTER_LEN, 8, consecutive `clk` cycles the synchronized PS/2 clock must hold a level before the filtered clock follows it (≥2)
- TIMEOUT_CYCLES, 50000, idle `clk` cycles allowed between filtered falling edges inside a frame (1 ms at 50 MHz)
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- PS2_CLOCK  input  1  raw PS/2 clock pin, asynchronous
- PS2_DATA  input  1  raw PS/2 data pin, asynchronous
- keycode  output  8  last good byte received; holds until next good byte
- is_pressed  output  1  one-cycle strobe, `keycode` updated this cycle
- parity_err  output  1  one-cycle strobe, frame dropped for bad parity
- frame_err  output  1  one-cycle strobe, frame dropped for bad start/stop bit or timeout

## Operation
- Reset: `keycode`=0x00, `is_pressed`=`parity_err`=`frame_err`=0, state IDLE, bit counter 0, sync flops and filtered clock =1, timeout counter 0.
- Input path: both pins through 2-flop synchronizers. Filtered clock changes to level v only after synchronized clock equals v for FILTER_LEN consecutive cycles; shorter pulses ignored.
- Falling edge event (`fe`): filtered clock 1→0, registered one cycle. Data sampled from synchronized PS2_DATA in the `fe` cycle.
- States: IDLE, DATA, PARITY, STOP.
  - IDLE: `fe` with data=0 → DATA, count=0. `fe` with data=1 → `frame_err` pulse, stay IDLE.
  - DATA: each `fe` shifts data into bit[count] (LSB first), count++; after 8th bit → PARITY.
  - PARITY: `fe` latches parity bit → STOP.
  - STOP: `fe` → IDLE. Stop=0 → `frame_err` (precedence over parity). Stop=1 and ones(data,parity) odd → load `keycode`, pulse `is_pressed`. Stop=1 and even → `parity_err`, `keycode` unchanged.
- Timeout: counter clears on every `fe` and in IDLE; outside IDLE, reaching TIMEOUT_CYCLES-1 → IDLE, `frame_err` pulse, partial byte discarded.
- At most one of `is_pressed`/`parity_err`/`frame_err` high in any cycle.
- `rst` mid-frame: immediate return to reset values; partial frame discarded, next complete frame received normally.

## Timing
- Pin edge to `fe`: 2 (sync) + FILTER_LEN (filter) + 1 (edge register) cycles.
- Stop-bit `fe` cycle N → `keycode`/`is_pressed`/error strobes registered, visible cycle N+1, high for exactly one cycle.
- Back-to-back frames: new start bit accepted on the first `fe` after STOP returns to IDLE; no dead time beyond that.
- Timeout and `fe` in the same cycle: `fe` wins, counter clears.
- Required clk ≥ 20× PS/2 clock (≤16.7 kHz) so filter delay < half PS/2 bit period.

## Structure
- `ps2_pkg`: state encodings (IDLE/DATA/PARITY/STOP), frame constants (DATA_BITS=8, START_BIT=0, STOP_BIT=1).
- One sub-module: `ps2_sync_filter` (2-flop sync + FILTER_LEN glitch filter + falling-edge detect), instantiated for PS2_CLOCK; PS2_DATA uses sync only.
- Deframer FSM, shift register, parity XOR, timeout counter in `ps2_rx`.

## Test plan
- Frame 0x1C, parity 0, stop 1, 12.5 kHz PS/2 clock → `keycode`=0x1C, single `is_pressed` pulse, no errors.
- Frames 0xF0 (parity 1) then 0x1C back-to-back → two `is_pressed` pulses, `keycode` 0xF0 then 0x1C.
- 0x1C with parity 1 → `parity_err` pulse, no `is_pressed`, `keycode` holds previous value; next good 0x32 → `keycode`=0x32.
- Start + 4 data bits then clock held high 2×TIMEOUT_CYCLES → one `frame_err`, state IDLE; following 0x1C received correctly.
- 3-cycle low glitches on PS2_CLOCK (FILTER_LEN=8) inside a 0x1C frame → ignored, `keycode`=0x1C; stop bit driven 0 → `frame_err` only.
- `rst` asserted after bit 5 of a frame → outputs at reset values immediately; subsequent 0xF0 frame → `keycode`=0xF0.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared deframer state encoding and PS/2 frame constants.
// Ports: none (package).
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/ps2_rx_if.sv
// ps2_rx_if: PS/2 pin inputs and received-byte/status outputs of the receiver.
// Signals: PS2_CLOCK, PS2_DATA raw pins; keycode last good byte;
//          is_pressed/parity_err/frame_err one-cycle strobes.
// Modports: master drives the pins and observes results, slave is the receiver.
interface ps2_rx_if;
    import ps2_pkg::*;

    logic                 PS2_CLOCK;
    logic                 PS2_DATA;
    logic [DATA_BITS-1:0] keycode;
    logic                 is_pressed;
    logic                 parity_err;
    logic                 frame_err;

    modport master (
        output PS2_CLOCK, PS2_DATA,
        input  keycode, is_pressed, parity_err, frame_err
    );

    modport slave (
        input  PS2_CLOCK, PS2_DATA,
        output keycode, is_pressed, parity_err, frame_err
    );

endinterface

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: 2-flop synchronizer, level glitch filter and registered falling-edge detect.
// Ports: clk, rst (async, active-high); pin_i raw asynchronous pin;
//        fe_o one-cycle pulse one cycle after the filtered level falls 1->0.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic fe_o
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;
    logic          fe_q;

    // Count consecutive cycles the synchronized level disagrees with the
    // filtered level; any agreeing cycle restarts the count.
    always_comb begin
        cnt_d  = (sync_q[1] == filt_q) ? '0 : cnt_q + CW'(1);
        filt_d = filt_q;
        if (cnt_d == CW'(FILTER_LEN)) begin
            filt_d = sync_q[1];
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            filt_q <= 1'b1;
            fe_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin_i};
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            fe_q   <= filt_q & ~filt_d;
        end
    end

    assign fe_o = fe_q;

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host byte receiver with parity/framing checks and stall timeout.
// Ports: clk, rst (async, active-high); bus (ps2_rx_if.slave): PS2_CLOCK/PS2_DATA raw pins in,
//        keycode last good byte, is_pressed/parity_err/frame_err one-cycle strobes out.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic     clk,
    input  logic     rst,
    ps2_rx_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic                 fe;
    logic [1:0]           dsync_q;
    logic                 din;
    state_t               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 tmo_hit;
    logic                 stop_fe;
    logic                 odd;
    logic [DATA_BITS-1:0] keycode_q, keycode_d;
    logic                 isp_q, isp_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk   (clk),
        .rst   (rst),
        .pin_i (bus.PS2_CLOCK),
        .fe_o  (fe)
    );

    assign din = dsync_q[1];

    // A falling edge in the same cycle as expiry keeps the frame alive.
    assign tmo_hit = (state_q != IDLE) && !fe && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign tmo_d   = (fe || state_q == IDLE || tmo_hit) ? '0 : tmo_q + TW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsync_q <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            dsync_q <= {dsync_q[0], bus.PS2_DATA};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        if (tmo_hit) begin
            state_d = IDLE;
        end else if (fe) begin
            case (state_q)
                IDLE: begin
                    state_d = (din == START_BIT) ? DATA : IDLE;
                    cnt_d   = '0;
                end
                DATA: begin
                    shift_d = {din, shift_q[DATA_BITS-1:1]};
                    cnt_d   = cnt_q + 3'd1;
                    state_d = (cnt_q == 3'(DATA_BITS - 1)) ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = din;
                    state_d = STOP;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A bad stop bit takes precedence over a parity check.
    assign stop_fe = fe && state_q == STOP;
    assign odd     = ^{shift_q, par_q};

    always_comb begin
        ferr_d    = tmo_hit || (fe && state_q == IDLE && din != START_BIT) || (stop_fe && din != STOP_BIT);
        isp_d     = stop_fe && din == STOP_BIT && odd;
        perr_d    = stop_fe && din == STOP_BIT && !odd;
        keycode_d = isp_d ? shift_q : keycode_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keycode_q <= '0;
            isp_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            keycode_q <= keycode_d;
            isp_q     <= isp_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.keycode    = keycode_q;
    assign bus.is_pressed = isp_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;

endmodule
